dma_cfg_slave: RTL and testbench

- AXI4 slave that sits directly upstream of the DMA master.
- The CPU programs the source address, destination address and transfer quantity through it, then issues a start.
- It drives the master's enable and configuration inputs, and collects the master's finish pulse into a sticky status bit and a level interrupt to the CPU.
- Register accesses support single-beat and burst transactions (FIXED and INCR bursts).

---
 rtl/dma_cfg_slave.sv | 179 +++++++++++++++++
 tb/tb_dma_cfg_slave.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cfg_slave.sv
// dma_cfg_slave: AXI4 register slave that programs and starts the DMA master and reports completion.
// Define DMA_SLV_WSTRB_EN to honour wstrb byte lanes on register writes.
module dma_cfg_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W = 8,
  parameter int LEN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  output logic              dma_en_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [DATA_W-1:0] data_qty_o,
  input  logic              dma_fin_i,
  output logic              irq_o
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [ID_W-1:0] w_id, r_id;
  logic [7:0] w_addr, r_addr, r_addr_nx;
  logic [LEN_W-1:0] w_len, w_cnt, r_len, r_cnt;
  logic w_fixed, r_fixed;
  logic [DATA_W-1:0] src, dst, qty, wmask;
  logic irq_en, busy, done, dma_en, irq;
  logic w_hs, w_end, r_hs, r_end, lane0, start, clr;
  logic unused;
  assign unused = ^{awaddr[ADDR_W-1:8], araddr[ADDR_W-1:8], awsize, arsize, wlast, wstrb};
`ifdef DMA_SLV_WSTRB_EN
  for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
    assign wmask[8*i +: 8] = {8{wstrb[i % 4]}};
  end
`else
  assign wmask = '1;
`endif
  assign awready = w_state == W_IDLE;
  assign wready = w_state == W_DATA;
  assign bvalid = w_state == W_RESP;
  assign bid = w_id;
  assign bresp = 2'b00;
  assign arready = r_state == R_IDLE;
  assign rvalid = r_state == R_DATA;
  assign rlast = rvalid && r_cnt == r_len;
  assign rid = r_id;
  assign rresp = 2'b00;
  assign dma_en_o = dma_en;
  assign irq_o = irq;
  assign src_addr_o = ADDR_W'(src);
  assign dst_addr_o = ADDR_W'(dst);
  assign data_qty_o = qty;
  assign w_hs = wready && wvalid;
  assign w_end = w_hs && w_cnt == w_len;
  assign r_hs = rvalid && rready;
  assign r_end = r_hs && rlast;
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: w_next = awvalid ? W_DATA : W_IDLE;
      W_DATA: w_next = w_end ? W_RESP : W_DATA;
      default: w_next = bready ? W_IDLE : W_RESP;
    endcase
  end
  always_comb begin
    r_next = r_state;
    r_next = r_state == R_IDLE ? (arvalid ? R_DATA : R_IDLE) : (r_end ? R_IDLE : R_DATA);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_id <= '0;
      w_addr <= '0;
      w_len <= '0;
      w_cnt <= '0;
      w_fixed <= 1'b0;
    end else if (awready && awvalid) begin
      w_id <= awid;
      w_addr <= awaddr[7:0];
      w_len <= awlen;
      w_cnt <= '0;
      w_fixed <= awburst == 2'b00;
    end else if (w_hs) begin
      w_cnt <= w_cnt + LEN_W'(1);
      w_addr <= w_fixed ? w_addr : w_addr + 8'd4;
    end
  function automatic logic [DATA_W-1:0] reg_rd(input logic [7:0] a);
    case (a[7:2])
      6'd0: reg_rd = src;
      6'd1: reg_rd = dst;
      6'd2: reg_rd = qty;
      6'd4: reg_rd = DATA_W'({done, busy});
      6'd5: reg_rd = DATA_W'(irq_en);
      default: reg_rd = '0;
    endcase
  endfunction
  // rdata is registered for the address the next beat will present
  assign r_addr_nx = r_state == R_IDLE ? araddr[7:0] : (r_fixed ? r_addr : r_addr + 8'd4);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_id <= '0;
      r_addr <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_fixed <= 1'b0;
      rdata <= '0;
    end else if (arready && arvalid) begin
      r_id <= arid;
      r_addr <= r_addr_nx;
      r_len <= arlen;
      r_cnt <= '0;
      r_fixed <= arburst == 2'b00;
      rdata <= reg_rd(r_addr_nx);
    end else if (r_hs && !rlast) begin
      r_cnt <= r_cnt + LEN_W'(1);
      r_addr <= r_addr_nx;
      rdata <= reg_rd(r_addr_nx);
    end
  assign lane0 = wmask[0];
  assign start = w_hs && w_addr[7:2] == 6'd3 && wdata[0] && lane0 && !busy;
  assign clr = w_hs && w_addr[7:2] == 6'd4 && wdata[1] && lane0;
  // a finish pulse overrides both a coincident start and a done clear
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      src <= '0;
      dst <= '0;
      qty <= '0;
      irq_en <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      dma_en <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (w_hs && !busy && w_addr[7:2] == 6'd0) src <= src & ~wmask | wdata & wmask;
      if (w_hs && !busy && w_addr[7:2] == 6'd1) dst <= dst & ~wmask | wdata & wmask;
      if (w_hs && !busy && w_addr[7:2] == 6'd2) qty <= qty & ~wmask | wdata & wmask;
      if (w_hs && w_addr[7:2] == 6'd5) irq_en <= lane0 ? wdata[0] : irq_en;
      dma_en <= start;
      busy <= dma_fin_i ? 1'b0 : (start | busy);
      done <= dma_fin_i | (done & ~start & ~clr);
      irq <= done & irq_en;
    end
endmodule

// File: tb/tb_dma_cfg_slave.sv
// tb_dma_cfg_slave: directed and randomized AXI register traffic checked against a register-map model.
module tb_dma_cfg_slave;
  localparam int ADDR_W = 32, DATA_W = 32, ID_W = 8, LEN_W = 8, TMO = 64;
`ifdef DMA_SLV_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr, src_addr_o, dst_addr_o;
  logic [LEN_W-1:0] awlen, arlen;
  logic [2:0] awsize, arsize;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [DATA_W-1:0] wdata, rdata, data_qty_o;
  logic [3:0] wstrb;
  logic dma_en_o, dma_fin_i, irq_o;
  int n_checks = 0, n_fail = 0, en_cnt = 0, m_starts = 0;
  logic [31:0] m_src = 0, m_dst = 0, m_qty = 0;
  logic m_ie = 0, m_busy = 0, m_done = 0;
  logic [31:0] wq[$];
  logic [3:0] sq[$];

  dma_cfg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dma_en_o(dma_en_o), .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .data_qty_o(data_qty_o), .dma_fin_i(dma_fin_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  // every low-phase sample with dma_en_o high is one cycle of pulse
  always @(negedge clk) if (dma_en_o) en_cnt++;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a[7:2])
      6'd0: return m_src;
      6'd1: return m_dst;
      6'd2: return m_qty;
      6'd4: return {30'd0, m_done, m_busy};
      6'd5: return {31'd0, m_ie};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input bit fin);
    logic [31:0] mk;
    mk = STRB_EN ? {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}} : 32'hFFFF_FFFF;
    case (a[7:2])
      6'd0: if (!m_busy) m_src = (m_src & ~mk) | (d & mk);
      6'd1: if (!m_busy) m_dst = (m_dst & ~mk) | (d & mk);
      6'd2: if (!m_busy) m_qty = (m_qty & ~mk) | (d & mk);
      6'd3: if (d[0] && mk[0] && !m_busy) begin m_busy = 1; m_done = 0; m_starts++; end
      6'd4: if (d[1] && mk[0]) m_done = 0;
      6'd5: if (mk[0]) m_ie = d[0];
      default: ;
    endcase
    if (fin) begin m_busy = 0; m_done = 1; end
  endfunction

  task automatic axi_write(input logic [7:0] a, input logic [1:0] burst, input bit fin_last);
    logic [7:0] ca = a;
    logic [ID_W-1:0] id = ID_W'($urandom);
    int t, len = wq.size() - 1;
    awid = id; awaddr = $urandom; awaddr[7:0] = a; awlen = LEN_W'(len);
    awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    t = 0;
    while (!awready && t < TMO) begin @(negedge clk); t++; end
    n_checks++;
    if (t == TMO) begin n_fail++; $display("FAIL aw_handshake: awready=%b required 1", awready); end
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wq[i]; wstrb = sq[i]; wlast = i == len; wvalid = 1'b1;
      t = 0;
      while (!wready && t < TMO) begin @(negedge clk); t++; end
      n_checks++;
      if (t == TMO) begin n_fail++; $display("FAIL w_handshake beat %0d: wready=%b required 1", i, wready); end
      dma_fin_i = fin_last && i == len;
      @(negedge clk);
      m_write(ca, wq[i], sq[i], fin_last && i == len);
      dma_fin_i = 1'b0;
      ca = burst == 2'b00 ? ca : ca + 8'd4;
    end
    wvalid = 1'b0; wlast = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < TMO) begin @(negedge clk); t++; end
    n_checks++;
    if (t == TMO || bid !== id || bresp !== 2'b00)
      begin n_fail++; $display("FAIL b_resp: bvalid=%b bid=%h bresp=%b required 1/%h/00", bvalid, bid, bresp, id); end
    @(negedge clk);
    bready = 1'b0;
    n_checks++;
    if (bvalid !== 1'b0) begin n_fail++; $display("FAIL b_single: bvalid=%b required 0", bvalid); end
    wq.delete(); sq.delete();
  endtask

  task automatic wr1(input logic [7:0] a, input logic [31:0] d);
    wq.push_back(d); sq.push_back(4'hF);
    axi_write(a, 2'b01, 1'b0);
  endtask

  task automatic axi_read(input logic [7:0] a, input int len, input logic [1:0] burst);
    logic [7:0] ca = a;
    logic [ID_W-1:0] id = ID_W'($urandom);
    int t;
    arid = id; araddr = $urandom; araddr[7:0] = a; arlen = LEN_W'(len);
    arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    t = 0;
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    n_checks++;
    if (t == TMO) begin n_fail++; $display("FAIL ar_handshake: arready=%b required 1", arready); end
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      rready = 1'b0;
      repeat ($urandom_range(0, 1)) @(negedge clk);
      rready = 1'b1;
      t = 0;
      while (!rvalid && t < TMO) begin @(negedge clk); t++; end
      n_checks++;
      if (t == TMO || rdata !== m_read(ca) || rid !== id || rresp !== 2'b00 || rlast !== (i == len))
        begin n_fail++; $display("FAIL r_beat a=%h beat %0d: rdata=%h rid=%h rresp=%b rlast=%b required %h/%h/00/%b",
          ca, i, rdata, rid, rresp, rlast, m_read(ca), id, i == len); end
      @(negedge clk);
      ca = burst == 2'b00 ? ca : ca + 8'd4;
    end
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL r_done: rvalid=%b required 0", rvalid); end
  endtask

  task automatic fin_pulse();
    dma_fin_i = 1'b1;
    @(negedge clk);
    dma_fin_i = 1'b0; m_busy = 0; m_done = 1;
    @(negedge clk);
  endtask

  task automatic verify_outputs();
    #1;
    n_checks++;
    if (src_addr_o !== m_src || dst_addr_o !== m_dst || data_qty_o !== m_qty)
      begin n_fail++; $display("FAIL cfg_out: %h/%h/%h required %h/%h/%h", src_addr_o, dst_addr_o, data_qty_o, m_src, m_dst, m_qty); end
    n_checks++;
    if (irq_o !== (m_done & m_ie)) begin n_fail++; $display("FAIL irq_level: irq_o=%b required %b", irq_o, m_done & m_ie); end
    n_checks++;
    if (en_cnt != m_starts) begin n_fail++; $display("FAIL start_cycles: dma_en cycles=%0d required %0d", en_cnt, m_starts); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, dma_en_o, irq_o} !== 7'b1100000)
      begin n_fail++; $display("FAIL reset_ctl: aw/ar/w/b/r/en/irq=%b required 1100000",
        {awready, arready, wready, bvalid, rvalid, dma_en_o, irq_o}); end
    n_checks++;
    if (src_addr_o !== 0 || dst_addr_o !== 0 || data_qty_o !== 0)
      begin n_fail++; $display("FAIL reset_cfg: %h/%h/%h required 0/0/0", src_addr_o, dst_addr_o, data_qty_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start();
    wr1(8'h00, 32'h0001_0000);
    wr1(8'h04, 32'h2000_0000);
    wr1(8'h08, 32'h0000_0300);
    wr1(8'h0C, 32'h1);
    verify_outputs();
    n_checks++;
    if (src_addr_o !== 32'h0001_0000 || dst_addr_o !== 32'h2000_0000 || data_qty_o !== 32'h300 || en_cnt != 1)
      begin n_fail++; $display("FAIL start_cfg: %h/%h/%h en=%0d required 00010000/20000000/00000300 en=1",
        src_addr_o, dst_addr_o, data_qty_o, en_cnt); end
    axi_read(8'h10, 0, 2'b01);
  endtask

  task automatic test_irq();
    wr1(8'h14, 32'h1);
    dma_fin_i = 1'b1;
    @(negedge clk);
    dma_fin_i = 1'b0; m_busy = 0; m_done = 1;
    #1;
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_lag: irq_o=%b required 0", irq_o); end
    @(negedge clk);
    #1;
    n_checks++;
    if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_set: irq_o=%b required 1", irq_o); end
    axi_read(8'h10, 0, 2'b00);
    wr1(8'h10, 32'h2);
    verify_outputs();
    axi_read(8'h10, 0, 2'b00);
  endtask

  task automatic test_incr_burst();
    logic [31:0] d[3];
    for (int i = 0; i < 3; i++) begin d[i] = $urandom; wq.push_back(d[i]); sq.push_back(4'hF); end
    axi_write(8'h00, 2'b01, 1'b0);
    verify_outputs();
    n_checks++;
    if (src_addr_o !== d[0] || dst_addr_o !== d[1] || data_qty_o !== d[2])
      begin n_fail++; $display("FAIL incr_burst: %h/%h/%h required %h/%h/%h", src_addr_o, dst_addr_o, data_qty_o, d[0], d[1], d[2]); end
    axi_read(8'h00, 2, 2'b01);
  endtask

  task automatic test_fixed_burst();
    logic [31:0] last = 0, keep;
    for (int i = 0; i < 4; i++) begin last = $urandom; wq.push_back(last); sq.push_back(4'hF); end
    axi_write(8'h04, 2'b00, 1'b0);
    verify_outputs();
    n_checks++;
    if (dst_addr_o !== last) begin n_fail++; $display("FAIL fixed_burst: dst=%h required %h", dst_addr_o, last); end
    wr1(8'h0C, 32'h1);
    keep = m_src;
    wr1(8'h00, 32'hDEAD);
    wr1(8'h0C, 32'h1);
    verify_outputs();
    n_checks++;
    if (src_addr_o !== keep || en_cnt != 2)
      begin n_fail++; $display("FAIL busy_lock: src=%h en=%0d required %h en=2", src_addr_o, en_cnt, keep); end
    fin_pulse();
    verify_outputs();
  endtask

  task automatic test_coincide();
    wq.push_back(32'h2); sq.push_back(4'hF);
    axi_write(8'h10, 2'b01, 1'b1);
    verify_outputs();
    n_checks++;
    if (m_done !== 1'b1 || irq_o !== 1'b1) begin n_fail++; $display("FAIL fin_w1c: irq_o=%b required 1", irq_o); end
    axi_read(8'h10, 0, 2'b01);
  endtask

  task automatic test_random();
    int op, len;
    logic [7:0] a;
    logic [1:0] b;
    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 5);
      a = 8'($urandom_range(0, 8) * 4 + $urandom_range(0, 3));
      b = $urandom_range(0, 1) ? 2'b01 : 2'b00;
      len = $urandom_range(0, 3);
      case (op)
        0, 1: begin wq.push_back($urandom); sq.push_back(4'($urandom)); axi_write(a, b, 1'b0); end
        2: begin
          for (int i = 0; i <= len; i++) begin wq.push_back($urandom); sq.push_back(4'($urandom)); end
          axi_write(a, b, 1'b0);
        end
        3: axi_read(a, len, b);
        4: if (m_busy) fin_pulse(); else @(negedge clk);
        default: begin wq.push_back($urandom); sq.push_back(4'($urandom)); axi_write(a, b, 1'b1); end
      endcase
      verify_outputs();
    end
  endtask

  task automatic test_reset_mid_read();
    int t;
    if (m_busy) fin_pulse();
    wr1(8'h00, 32'hCAFE_0001);
    wr1(8'h14, 32'h1);
    wr1(8'h10, 32'h2);
    fin_pulse();
    verify_outputs();
    arid = 8'h5A; araddr = 0; arlen = 3; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
    t = 0;
    while (!arready && t < TMO) begin @(negedge clk); t++; end
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    t = 0;
    while (!rvalid && t < TMO) begin @(negedge clk); t++; end
    @(negedge clk);
    rready = 1'b0;
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== m_dst)
      begin n_fail++; $display("FAIL mid_beat1: rvalid=%b rdata=%h required 1/%h", rvalid, rdata, m_dst); end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({awready, arready, wready, bvalid, rvalid, dma_en_o, irq_o} !== 7'b1100000)
      begin n_fail++; $display("FAIL mid_reset_ctl: aw/ar/w/b/r/en/irq=%b required 1100000",
        {awready, arready, wready, bvalid, rvalid, dma_en_o, irq_o}); end
    n_checks++;
    if (src_addr_o !== 0 || dst_addr_o !== 0 || data_qty_o !== 0)
      begin n_fail++; $display("FAIL mid_reset_cfg: %h/%h/%h required 0/0/0", src_addr_o, dst_addr_o, data_qty_o); end
    @(negedge clk);
    rst = 1'b0;
    m_src = 0; m_dst = 0; m_qty = 0; m_ie = 0; m_busy = 0; m_done = 0;
    @(negedge clk);
    axi_read(8'h00, 5, 2'b01);
    verify_outputs();
  endtask

  initial begin
    {awvalid, wvalid, bready, arvalid, rready, dma_fin_i, wlast} = '0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
    arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
    test_reset();
    test_start();
    test_irq();
    test_incr_burst();
    test_fixed_burst();
    test_coincide();
    test_random();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
